// File: rtl/rr_mux_pipe_pkg.sv
// rr_mux_pipe_pkg: shared types and widths for the round-robin mux pipeline
package rr_mux_pipe_pkg;
  localparam int DATA_W = 8;
  localparam int SRC_W = 1;
  typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic last;
    logic [SRC_W-1:0] src;
  } beat_t;
endpackage

// File: rtl/rr_mux_pipe_ctrl_pipe_stage.sv
// pipe_stage: one register stage that loads its input whenever enabled
module pipe_stage
  import rr_mux_pipe_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  in_valid,
  input  beat_t in_beat,
  output logic  valid,
  output beat_t beat
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      beat  <= '0;
    end else if (en) begin
      valid <= in_valid;
      beat  <= in_beat;
    end
  end
endmodule

// File: rtl/rr_mux_pipe_ctrl.sv
// rr_mux_pipe_ctrl: packet-locked round-robin 2:1 mux feeding a 2-stage handshake pipeline
module rr_mux_pipe_ctrl
  import rr_mux_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  input  logic              last0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  input  logic              last1,
  output logic              gnt1,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_src,
  input  logic              out_ready
);
  state_t state;
  logic rr_ptr, sel, acc, adv2, xfer, s1_valid, s2_valid;
  beat_t in_beat, s1_beat, s2_beat;
  always_comb begin
    adv2 = ~s2_valid | out_ready;
    acc  = ~s1_valid | adv2;
    // a locked packet owner keeps the select; otherwise the pointer breaks ties
    sel  = (state == LOCK1) ? 1'b1 : (state == LOCK0) ? 1'b0 : (req0 & req1) ? rr_ptr : req1;
    gnt0 = rst_n & acc & ~sel & req0;
    gnt1 = rst_n & acc & sel & req1;
    xfer = gnt0 | gnt1;
    in_beat.data = sel ? data1 : data0;
    in_beat.last = sel ? last1 : last0;
    in_beat.src  = sel;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else if (xfer) begin
      state  <= in_beat.last ? IDLE : (sel ? LOCK1 : LOCK0);
      rr_ptr <= in_beat.last ? ~sel : rr_ptr;
    end
  end
  pipe_stage u_s1 (
    .clk(clk), .rst_n(rst_n), .en(acc), .in_valid(xfer), .in_beat(in_beat),
    .valid(s1_valid), .beat(s1_beat)
  );
  pipe_stage u_s2 (
    .clk(clk), .rst_n(rst_n), .en(adv2), .in_valid(s1_valid), .in_beat(s1_beat),
    .valid(s2_valid), .beat(s2_beat)
  );
  assign out_valid = s2_valid;
  assign out_data  = s2_beat.data;
  assign out_last  = s2_beat.last;
  assign out_src   = s2_beat.src;
endmodule
